// File: rtl/reg_stage_skid_pkg.sv
// reg_stage_skid_pkg: shared state encoding and payload width constants for the skid stage.
package reg_stage_skid_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    localparam int          LENGTH         = 32;
    localparam logic [31:0] INITIAL_VAL_32 = 32'h0000_0000;
    // MEM/WB bundle: result + store data + rd + reg_write + mem_to_reg
    localparam int          MEMWB_W        = 32 + 32 + 5 + 1 + 1;

endpackage

// File: rtl/reg_stage_skid_sat_counter.sv
// sat_counter: saturating up-counter used for stall accounting.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (inc && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/reg_stage_skid.sv
// reg_stage_skid: two-entry valid/ready pipeline stage with registered in_ready.
// Define STAGE_STALL_CNT_EN to add the saturating stall_cnt output.
module reg_stage_skid
    import reg_stage_skid_pkg::*;
#(
    parameter int DATA_W = MEMWB_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    input  logic              flush
`ifdef STAGE_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    state_e            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              acc, take;

    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign in_ready  = in_ready_q;

    always_comb begin
        acc     = in_valid && in_ready_q && !flush;
        take    = out_valid && out_ready;
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (acc) begin
                    main_d  = in_data;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (acc && take) main_d = in_data;
                if (acc && !take) skid_d = in_data;
                state_d = acc ? (take ? ONE : TWO) : (take ? EMPTY : ONE);
            end
            TWO: begin
                if (take) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        // flush only squashes occupancy; stale data is never visible
        if (flush) state_d = EMPTY;
        in_ready_d = (state_d != TWO);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
        end
    end

`ifdef STAGE_STALL_CNT_EN
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (out_valid && !out_ready),
        .cnt (stall_cnt)
    );
`endif

endmodule

// File: tb/tb_reg_stage_skid.sv
// tb_reg_stage_skid: randomized and directed checks of reg_stage_skid against a queue model.
module tb_reg_stage_skid;

    localparam int W = 70;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready = 1'b0;
    logic         flush = 1'b0;
`ifdef STAGE_STALL_CNT_EN
    logic [3:0]   stall_cnt;
`endif

    int total = 0;
    int bad = 0;

    logic [W-1:0] q[$];
    bit           rdy = 1'b0;
    int           stall_m = 0;

    always #5 clk = ~clk;

`ifdef STAGE_STALL_CNT_EN
    reg_stage_skid #(.DATA_W(W), .CNT_W(4)) dut (
`else
    reg_stage_skid #(.DATA_W(W)) dut (
`endif
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .flush     (flush)
`ifdef STAGE_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    function automatic logic [W-1:0] rnd();
        return W'({$urandom, $urandom, $urandom});
    endfunction

    task automatic model_reset();
        q.delete();
        rdy = 1'b0;
        stall_m = 0;
    endtask

    // One clock: apply inputs, advance the model by the stage's transfer rules.
    task automatic drive(input bit v, input logic [W-1:0] d, input bit r, input bit f);
        bit acc, tk;
        in_valid = v; in_data = d; out_ready = r; flush = f;
        @(posedge clk);
        acc = v && rdy && !f;
        tk  = (q.size() > 0) && r;
        if (q.size() > 0 && !r && stall_m < 15) stall_m++;
        if (f) q.delete();
        else begin
            if (tk) void'(q.pop_front());
            if (acc) q.push_back(d);
        end
        rdy = (q.size() < 2);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
        total++; if (out_data !== '0) begin bad++; $display("FAIL rst_out_data got=%h exp=0", out_data); end
        rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rel_in_ready_early got=%b exp=0", in_ready); end
        drive(0, '0, 0, 0);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rel_in_ready got=%b exp=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rel_out_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== '0) begin bad++; $display("FAIL rel_out_data got=%h exp=0", out_data); end
    endtask

    task automatic test_stream();
        for (int i = 1; i <= 8; i++) begin
            drive(1, W'(i), 1, 0);
            total++; if (out_data !== W'(i)) begin bad++; $display("FAIL stream_data[%0d] got=%h exp=%h", i, out_data, W'(i)); end
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, out_valid); end
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_ready[%0d] got=%b exp=1", i, in_ready); end
        end
        drive(0, '0, 1, 0);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] a, b, c;
        a = rnd(); b = rnd(); c = rnd();
        drive(1, a, 0, 0);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_a got=%b exp=1", in_ready); end
        drive(1, b, 0, 0);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_b got=%b exp=0", in_ready); end
        drive(1, c, 0, 0);
        total++; if (out_data !== a) begin bad++; $display("FAIL bp_hold_a got=%h exp=%h", out_data, a); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_c got=%b exp=0", in_ready); end
        drive(1, c, 1, 0);
        total++; if (out_data !== b) begin bad++; $display("FAIL bp_out_b got=%h exp=%h", out_data, b); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_reopen got=%b exp=1", in_ready); end
        drive(1, c, 1, 0);
        total++; if (out_data !== c || out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_c got=%h/%b exp=%h/1", out_data, out_valid, c); end
        drive(0, '0, 1, 0);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_flush();
        drive(1, rnd(), 0, 0);
        drive(1, rnd(), 0, 0);
        drive(1, rnd(), 0, 1);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b exp=1", in_ready); end
        drive(0, '0, 1, 0);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_dropped_c got=%b exp=0", out_valid); end
    endtask

    task automatic test_async_reset();
        drive(1, rnd(), 0, 0);
        drive(1, rnd(), 0, 0);
        #2 rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL arst_ready got=%b exp=0", in_ready); end
        model_reset();
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        drive(0, '0, 0, 0);
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL arst_release got=%b/%b exp=1/0", in_ready, out_valid); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, rnd(), $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
            total++; if (out_valid !== (q.size() != 0)) begin bad++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", i, out_valid, q.size() != 0); end
            total++; if (in_ready !== rdy) begin bad++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", i, in_ready, rdy); end
            if (q.size() != 0) begin
                total++; if (out_data !== q[0]) begin bad++; $display("FAIL rnd_data[%0d] got=%h exp=%h", i, out_data, q[0]); end
            end
`ifdef STAGE_STALL_CNT_EN
            total++; if (stall_cnt !== 4'(stall_m)) begin bad++; $display("FAIL rnd_stall[%0d] got=%0d exp=%0d", i, stall_cnt, stall_m); end
`endif
        end
        drive(0, '0, 0, 1);
    endtask

`ifdef STAGE_STALL_CNT_EN
    task automatic test_stall_cnt();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(0, '0, 0, 0);
        drive(1, rnd(), 0, 0);
        repeat (20) drive(0, '0, 0, 0);
        total++; if (stall_cnt !== 4'd15) begin bad++; $display("FAIL stall_sat got=%0d exp=15", stall_cnt); end
        drive(0, '0, 0, 1);
        total++; if (stall_cnt !== 4'd15) begin bad++; $display("FAIL stall_flush got=%0d exp=15", stall_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
`ifdef STAGE_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
